rv32im_branch_unit: RTL and testbench

Resolves conditional branches and JAL/JALR in the RV32IM execute stage. It is the consumer of the ALU's registered comparison flags (`equal`, `less`, `less_signed`) and result. It issues a single-cycle redirect (`jump_o`, target) and holds a multi-cycle pipeline flush. It captures control-flow instructions on the same issue strobe the ALU sees, then resolves them one cycle later when the ALU flags are valid.

---
 rtl/rv32im_branch_unit_pkg.sv | 11 +
 rtl/rv32im_branch_unit_if.sv | 31 +++
 rtl/rv32im_branch_cond.sv | 19 +
 rtl/rv32im_branch_unit.sv | 119 +++++++++++
 tb/tb_rv32im_branch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32im_branch_unit_pkg.sv
// rv32im_branch_unit_pkg: shared funct3 codes, FSM states and instruction kinds for the branch unit
package rv32im_branch_unit_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EVAL = 2'd1, ST_FLUSH = 2'd2} state_e;
    typedef enum logic [1:0] {K_BR = 2'd0, K_JAL = 2'd1, K_JALR = 2'd2} kind_e;
endpackage

// File: rtl/rv32im_branch_unit_if.sv
// rv32im_branch_unit_if: issue/ALU-flag inputs and redirect/flush outputs of the branch unit
// master: issue stage + ALU (drives *_i, reads *_o); slave: the branch unit
interface rv32im_branch_unit_if #(parameter int XLEN = 32);
    logic            data_ready_i;
    logic            branch_i;
    logic            jal_i;
    logic            jalr_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            equal_i;
    logic            less_i;
    logic            less_signed_i;
    logic [XLEN-1:0] alu_result_i;
    logic            jump_o;
    logic [XLEN-1:0] jump_target_o;
    logic [XLEN-1:0] link_o;
    logic            flush_o;
    logic            busy_o;
    logic            misaligned_o;
    modport master (
        output data_ready_i, branch_i, jal_i, jalr_i, funct3_i, pc_i, imm_i,
               equal_i, less_i, less_signed_i, alu_result_i,
        input  jump_o, jump_target_o, link_o, flush_o, busy_o, misaligned_o
    );
    modport slave (
        input  data_ready_i, branch_i, jal_i, jalr_i, funct3_i, pc_i, imm_i,
               equal_i, less_i, less_signed_i, alu_result_i,
        output jump_o, jump_target_o, link_o, flush_o, busy_o, misaligned_o
    );
endinterface

// File: rtl/rv32im_branch_cond.sv
// rv32im_branch_cond: funct3 + ALU flags -> branch taken (010/011 never taken)
// ports: funct3_i, equal_i, less_i (unsigned), less_signed_i in; taken_o out
module rv32im_branch_cond
    import rv32im_branch_unit_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       equal_i,
    input  logic       less_i,
    input  logic       less_signed_i,
    output logic       taken_o
);
    always_comb
        taken_o = funct3_i == F3_BEQ  ?  equal_i       :
                  funct3_i == F3_BNE  ? ~equal_i       :
                  funct3_i == F3_BLT  ?  less_signed_i :
                  funct3_i == F3_BGE  ? ~less_signed_i :
                  funct3_i == F3_BLTU ?  less_i        :
                  funct3_i == F3_BGEU ? ~less_i        : 1'b0;
endmodule

// File: rtl/rv32im_branch_unit.sv
// rv32im_branch_unit: captures branch/JAL/JALR at issue, resolves one cycle later, redirects and flushes
// ports: clk_i, clear_i (sync active-high reset), bus (rv32im_branch_unit_if.slave)
// optional RV32IM_BRANCH_MISALIGN_EN: a taken target with bit 1 set faults instead of jumping
module rv32im_branch_unit
    import rv32im_branch_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk_i,
    input logic                 clear_i,
    rv32im_branch_unit_if.slave bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] tgt_q, tgt_d, lnk_q, lnk_d, jt_q, jt_d, link_q, link_d;
    logic            jump_q, jump_d, flush_q, flush_d, mis_q, mis_d;
    logic            cond_taken, taken, bad;
    logic [XLEN-1:0] target;

    rv32im_branch_cond u_cond (
        .funct3_i      (f3_q),
        .equal_i       (bus.equal_i),
        .less_i        (bus.less_i),
        .less_signed_i (bus.less_signed_i),
        .taken_o       (cond_taken)
    );

    assign taken  = kind_q != K_BR || cond_taken;
    assign target = kind_q == K_JALR ? bus.alu_result_i & ~XLEN'(1) : tgt_q;
`ifdef RV32IM_BRANCH_MISALIGN_EN
    assign bad = target[1];
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        tgt_d   = tgt_q;
        lnk_d   = lnk_q;
        jt_d    = jt_q;
        link_d  = link_q;
        jump_d  = 1'b0;
        mis_d   = 1'b0;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE:
                if (bus.data_ready_i && (bus.branch_i || bus.jal_i || bus.jalr_i)) begin
                    state_d = ST_EVAL;
                    kind_d  = bus.jalr_i ? K_JALR : bus.jal_i ? K_JAL : K_BR;
                    f3_d    = bus.funct3_i;
                    tgt_d   = bus.pc_i + bus.imm_i;
                    lnk_d   = bus.pc_i + XLEN'(4);
                end
            ST_EVAL: begin
                state_d = ST_IDLE;
                mis_d   = taken && bad;
                if (taken && !bad) begin
                    state_d = ST_FLUSH;
                    jump_d  = 1'b1;
                    flush_d = 1'b1;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    jt_d    = target;
                    link_d  = lnk_q;
                end
            end
            ST_FLUSH:
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= ST_IDLE;
            kind_q  <= K_BR;
            cnt_q   <= '0;
            f3_q    <= '0;
            tgt_q   <= '0;
            lnk_q   <= '0;
            jt_q    <= '0;
            link_q  <= '0;
            jump_q  <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            tgt_q   <= tgt_d;
            lnk_q   <= lnk_d;
            jt_q    <= jt_d;
            link_q  <= link_d;
            jump_q  <= jump_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.jump_o        = jump_q;
    assign bus.jump_target_o = jt_q;
    assign bus.link_o        = link_q;
    assign bus.flush_o       = flush_q;
    assign bus.busy_o        = state_q != ST_IDLE;
    assign bus.misaligned_o  = mis_q;
endmodule

// File: tb/tb_rv32im_branch_unit.sv
// tb_rv32im_branch_unit: directed + randomized transactions checked against a transaction-level model
module tb_rv32im_branch_unit;
    localparam int FC = 2;
`ifdef RV32IM_BRANCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic clear_i;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] last_tgt = '0;
    logic [31:0] last_lnk = '0;

    rv32im_branch_unit_if #(.XLEN(32)) bus ();

    rv32im_branch_unit #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
        .clk_i   (clk_i),
        .clear_i (clear_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.data_ready_i  = 1'b0;
        bus.branch_i      = 1'b0;
        bus.jal_i         = 1'b0;
        bus.jalr_i        = 1'b0;
        bus.funct3_i      = 3'($urandom);
        bus.pc_i          = $urandom;
        bus.imm_i         = $urandom;
        bus.equal_i       = 1'($urandom);
        bus.less_i        = 1'($urandom);
        bus.less_signed_i = 1'($urandom);
        bus.alu_result_i  = $urandom;
    endtask

    // RISC-V branch semantics on the source operands
    function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // k: 0 branch, 1 JAL, 2 JALR. Entered and left in a cycle where the unit is idle.
    task automatic run_txn(input int k, input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input bit eq, input bit lt, input bit lts, input logic [31:0] alu,
                           input bit exp_taken, input bit pulse);
        logic [31:0] tgt;
        bit mis, jmp;
        tgt = k == 2 ? {alu[31:1], 1'b0} : pc + imm;
        mis = MIS_EN && exp_taken && tgt[1];
        jmp = exp_taken && !mis;
        chk("issue_busy", bus.busy_o, 1'b0);
        idle_inputs();
        bus.data_ready_i = 1'b1;
        bus.branch_i     = k == 0;
        bus.jal_i        = k == 1;
        bus.jalr_i       = k == 2;
        bus.funct3_i     = f3;
        bus.pc_i         = pc;
        bus.imm_i        = imm;
        tick();
        idle_inputs();
        bus.data_ready_i  = pulse;
        bus.branch_i      = pulse;
        bus.equal_i       = eq;
        bus.less_i        = lt;
        bus.less_signed_i = lts;
        bus.alu_result_i  = alu;
        chk("eval_busy", bus.busy_o, 1'b1);
        chk("eval_jump", bus.jump_o, 1'b0);
        chk("eval_flush", bus.flush_o, 1'b0);
        tick();
        idle_inputs();
        if (jmp) begin
            last_tgt = tgt;
            last_lnk = pc + 32'd4;
        end
        chk("res_jump", bus.jump_o, jmp);
        chk("res_mis", bus.misaligned_o, mis);
        chk("res_flush", bus.flush_o, jmp);
        chk("res_busy", bus.busy_o, jmp);
        chk("res_target", bus.jump_target_o, last_tgt);
        chk("res_link", bus.link_o, last_lnk);
        if (jmp) begin
            for (int i = 1; i < FC; i++) begin
                tick();
                chk("fl_flush", bus.flush_o, 1'b1);
                chk("fl_busy", bus.busy_o, 1'b1);
                chk("fl_jump", bus.jump_o, 1'b0);
            end
            tick();
            chk("end_flush", bus.flush_o, 1'b0);
            chk("end_jump", bus.jump_o, 1'b0);
            chk("hold_target", bus.jump_target_o, last_tgt);
            chk("hold_link", bus.link_o, last_lnk);
        end
    endtask

    initial begin
        logic [31:0] a, b, pc, imm, alu;
        logic [2:0] f3;
        int k;
        idle_inputs();
        clear_i = 1'b1;
        tick();
        tick();
        clear_i = 1'b0;
        chk("rst_jump", bus.jump_o, 1'b0);
        chk("rst_flush", bus.flush_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_mis", bus.misaligned_o, 1'b0);
        chk("rst_target", bus.jump_target_o, 32'h0);
        chk("rst_link", bus.link_o, 32'h0);

        // BEQ taken, pc 0x100 + 0x20
        run_txn(0, 3'b000, 32'h100, 32'h20, 1, 0, 0, $urandom, 1, 0);
        chk("beq_target", bus.jump_target_o, 32'h120);
        // BLTU not taken, then an immediate back-to-back issue in cycle 2
        run_txn(0, 3'b110, 32'h200, 32'h40, 0, 0, 1, $urandom, 0, 0);
        run_txn(0, 3'b001, 32'h300, 32'h8, 0, 0, 0, $urandom, 1, 0);
        // JALR to 0x203 -> 0x202 (faults instead when misalign checking is built in)
        run_txn(2, 3'b000, 32'h40, 32'h0, 0, 0, 0, 32'h203, 1, 0);
        if (!MIS_EN) chk("jalr_target", bus.jump_target_o, 32'h202);
        if (!MIS_EN) chk("jalr_link", bus.link_o, 32'h44);
        // JAL wrapping around the address space
        run_txn(1, 3'b000, 32'hFFFF_FFF8, 32'h10, 0, 0, 0, $urandom, 1, 0);
        chk("jal_target", bus.jump_target_o, 32'h8);
        chk("jal_link", bus.link_o, 32'hFFFF_FFFC);
        // funct3 010 with all flags set, plus an issue pulse during EVAL that must be ignored
        run_txn(0, 3'b010, 32'h500, 32'h10, 1, 1, 1, $urandom, 0, 1);
        tick();
        chk("no_recapture", bus.busy_o, 1'b0);

        // clear in the first FLUSH cycle
        bus.data_ready_i = 1'b1;
        bus.branch_i     = 1'b1;
        bus.funct3_i     = 3'b000;
        bus.pc_i         = 32'h600;
        bus.imm_i        = 32'h40;
        tick();
        idle_inputs();
        bus.equal_i = 1'b1;
        tick();
        idle_inputs();
        chk("clr_pre_jump", bus.jump_o, 1'b1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_jump", bus.jump_o, 1'b0);
        chk("clr_flush", bus.flush_o, 1'b0);
        chk("clr_busy", bus.busy_o, 1'b0);
        chk("clr_target", bus.jump_target_o, 32'h0);
        chk("clr_link", bus.link_o, 32'h0);
        last_tgt = '0;
        last_lnk = '0;
        run_txn(0, 3'b001, 32'h700, 32'hFFFF_FFF0, 0, 1, 0, $urandom, 1, 0);
        chk("bne_target", bus.jump_target_o, 32'h6F0);

        // randomized transactions with flags derived from random operands
        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 2);
            f3  = 3'($urandom);
            a   = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
            b   = $urandom_range(0, 3) == 0 ? a : $urandom;
            pc  = $urandom;
            imm = $urandom;
            alu = $urandom;
            run_txn(k, f3, pc, imm, a == b, a < b, $signed(a) < $signed(b), alu,
                    k != 0 || br_taken(f3, a, b), 1'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
